mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 20 ++
 rtl/rr_arbiter2.sv | 47 ++++
 rtl/mem_arbiter.sv | 123 ++++++++++++
 tb/tb_mem_arbiter.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the dual-core memory arbiter: default sizes,
// core identifiers and a small helper used by the grant logic.
package mem_arbiter_pkg;

    localparam int DEPTH_LOG2_DEFAULT = 8;
    localparam int CNT_W_DEFAULT      = 16;
    localparam int WORD_W             = 32;

    // Core identifiers; the encoding doubles as the last_grant value.
    typedef enum logic {
        CORE0 = 1'b0,
        CORE1 = 1'b1
    } core_id_t;

    // The core that is not `id`; used to hand priority to the loser.
    function automatic core_id_t other_core(input core_id_t id);
        return (id == CORE0) ? CORE1 : CORE0;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter. Grants are combinational in the
// request cycle; the favor register names the tie winner and flips to the
// loser after every granted cycle.
module rr_arbiter2
    import mem_arbiter_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     req0,
    input  logic     req1,
    output logic     gnt0,
    output logic     gnt1,
    output core_id_t winner
);

    core_id_t favor;
    core_id_t favor_next;

    // Priority register: core0 wins the first tie after reset.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            favor <= CORE0;
        end else begin
            favor <= favor_next;
        end
    end

    // Grant decode: a lone requester always wins, a tie goes to favor.
    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        gnt0       = 1'b0;
        gnt1       = 1'b0;
        winner     = CORE0;
        favor_next = favor;
        if (req0 && (!req1 || favor == CORE0)) begin
            gnt0       = 1'b1;
            winner     = CORE0;
            favor_next = other_core(CORE0);
        end else if (req1) begin
            gnt1       = 1'b1;
            winner     = CORE1;
            favor_next = other_core(CORE1);
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shared word-addressed data memory for two cores behind a round-robin
// arbiter, with per-core grant and contention statistics.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int DEPTH_LOG2 = DEPTH_LOG2_DEFAULT,
    parameter int CNT_W      = CNT_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              c0_MemRequest,
    input  logic              c0_MemRead,
    input  logic              c0_MemWrite,
    input  logic [31:0]       c0_MemAddress,
    input  logic [31:0]       c0_MemWriteData,
    output logic [31:0]       c0_MemReadData,
    output logic              c0_MemGrant,
    input  logic              c1_MemRequest,
    input  logic              c1_MemRead,
    input  logic              c1_MemWrite,
    input  logic [31:0]       c1_MemAddress,
    input  logic [31:0]       c1_MemWriteData,
    output logic [31:0]       c1_MemReadData,
    output logic              c1_MemGrant,
    output logic              last_grant,
    output logic [CNT_W-1:0]  grant_count0,
    output logic [CNT_W-1:0]  grant_count1,
    output logic [CNT_W-1:0]  contention_count
);

    localparam int WORDS = 1 << DEPTH_LOG2;

    logic [WORD_W-1:0]     mem [WORDS];
    logic [DEPTH_LOG2-1:0] idx0;
    logic [DEPTH_LOG2-1:0] idx1;
    logic [DEPTH_LOG2-1:0] wr_idx;
    logic [WORD_W-1:0]     wr_data;
    logic                  wr_en;
    logic                  gnt0;
    logic                  gnt1;
    core_id_t              winner;
    logic                  unused_inputs;

    // Word index: byte offset and bits above the array size are dropped.
    assign idx0 = c0_MemAddress[DEPTH_LOG2+1:2];
    assign idx1 = c1_MemAddress[DEPTH_LOG2+1:2];

    // Loads need no strobe of their own: read data follows the grant.
    assign unused_inputs = ^{c0_MemRead, c1_MemRead,
                             c0_MemAddress[31:DEPTH_LOG2+2], c0_MemAddress[1:0],
                             c1_MemAddress[31:DEPTH_LOG2+2], c1_MemAddress[1:0]};

    rr_arbiter2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .req0   (c0_MemRequest),
        .req1   (c1_MemRequest),
        .gnt0   (gnt0),
        .gnt1   (gnt1),
        .winner (winner)
    );

    assign c0_MemGrant = gnt0;
    assign c1_MemGrant = gnt1;

    // Route the granted core's store onto the single write port.
    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = idx0;
        wr_data = c0_MemWriteData;
        if (gnt0) begin
            wr_en = c0_MemWrite;
        end else if (gnt1) begin
            wr_en   = c1_MemWrite;
            wr_idx  = idx1;
            wr_data = c1_MemWriteData;
        end
    end

    // Memory write port; same-cycle loads still see the old word.
    // NOTE: the storage array has no reset; rst only blocks writes while it is held.
    always_ff @(posedge clk) begin
        if (!rst && wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    // Asynchronous read ports, forced to zero for a core without a grant.
    always_comb begin
        c0_MemReadData = '0;
        c1_MemReadData = '0;
        if (gnt0) begin
            c0_MemReadData = mem[idx0];
        end
        if (gnt1) begin
            c1_MemReadData = mem[idx1];
        end
    end

    // Last-grant ID and saturating statistics counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant       <= CORE0;
            grant_count0     <= '0;
            grant_count1     <= '0;
            contention_count <= '0;
        end else begin
            if (gnt0 || gnt1) begin
                last_grant <= winner;
            end
            if (gnt0 && grant_count0 != '1) begin
                grant_count0 <= grant_count0 + CNT_W'(1);
            end
            if (gnt1 && grant_count1 != '1) begin
                grant_count1 <= grant_count1 + CNT_W'(1);
            end
            if (c0_MemRequest && c1_MemRequest && contention_count != '1) begin
                contention_count <= contention_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized traffic, all
// checked against a behavioural model of arbitration, memory and counters.
module tb_mem_arbiter;

    localparam int DEPTH_LOG2 = 8;
    localparam int WORDS      = 1 << DEPTH_LOG2;
    localparam int CMAX       = 65535;
    localparam int S_CNT_W    = 3;

    typedef struct {
        logic        req;
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    logic clk = 1'b0;
    logic rst;

    logic        c0_MemRequest, c0_MemRead, c0_MemWrite;
    logic [31:0] c0_MemAddress, c0_MemWriteData, c0_MemReadData;
    logic        c0_MemGrant;
    logic        c1_MemRequest, c1_MemRead, c1_MemWrite;
    logic [31:0] c1_MemAddress, c1_MemWriteData, c1_MemReadData;
    logic        c1_MemGrant;
    logic        last_grant;
    logic [15:0] grant_count0, grant_count1, contention_count;

    // Narrow-counter instance used to reach saturation quickly.
    logic               s_c0_req, s_c1_req;
    logic [31:0]        s_c0_rdata, s_c1_rdata;
    logic               s_c0_gnt, s_c1_gnt, s_last;
    logic [S_CNT_W-1:0] s_cnt0, s_cnt1, s_cont;

    int tests_run = 0;
    int fails     = 0;

    // Reference model state
    int          favor_m, last_m, cnt0_m, cnt1_m, cont_m;
    logic [31:0] mem_m [int];

    always #5 clk = ~clk;

    mem_arbiter #(.DEPTH_LOG2(DEPTH_LOG2), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .c0_MemRequest(c0_MemRequest), .c0_MemRead(c0_MemRead), .c0_MemWrite(c0_MemWrite),
        .c0_MemAddress(c0_MemAddress), .c0_MemWriteData(c0_MemWriteData),
        .c0_MemReadData(c0_MemReadData), .c0_MemGrant(c0_MemGrant),
        .c1_MemRequest(c1_MemRequest), .c1_MemRead(c1_MemRead), .c1_MemWrite(c1_MemWrite),
        .c1_MemAddress(c1_MemAddress), .c1_MemWriteData(c1_MemWriteData),
        .c1_MemReadData(c1_MemReadData), .c1_MemGrant(c1_MemGrant),
        .last_grant(last_grant), .grant_count0(grant_count0),
        .grant_count1(grant_count1), .contention_count(contention_count)
    );

    mem_arbiter #(.DEPTH_LOG2(4), .CNT_W(S_CNT_W)) sat_dut (
        .clk(clk), .rst(rst),
        .c0_MemRequest(s_c0_req), .c0_MemRead(1'b0), .c0_MemWrite(1'b0),
        .c0_MemAddress(32'h0), .c0_MemWriteData(32'h0),
        .c0_MemReadData(s_c0_rdata), .c0_MemGrant(s_c0_gnt),
        .c1_MemRequest(s_c1_req), .c1_MemRead(1'b0), .c1_MemWrite(1'b0),
        .c1_MemAddress(32'h0), .c1_MemWriteData(32'h0),
        .c1_MemReadData(s_c1_rdata), .c1_MemGrant(s_c1_gnt),
        .last_grant(s_last), .grant_count0(s_cnt0),
        .grant_count1(s_cnt1), .contention_count(s_cont)
    );

    function automatic int sat_inc(input int v);
        return (v < CMAX) ? v + 1 : v;
    endfunction

    function automatic int word_of(input logic [31:0] addr);
        return int'((addr / 4) % WORDS);
    endfunction

    function automatic req_t mk(input logic req, input logic rd, input logic wr,
                                input logic [31:0] addr, input logic [31:0] wdata);
        req_t r;
        r.req = req; r.rd = rd; r.wr = wr; r.addr = addr; r.wdata = wdata;
        return r;
    endfunction

    function automatic req_t rand_req();
        req_t        r;
        int          op;
        logic [31:0] hi;
        hi      = $urandom;
        op      = $urandom_range(0, 2);
        r.req   = ($urandom_range(0, 9) < 7);
        r.rd    = (op == 1);
        r.wr    = (op == 2);
        r.addr  = (hi & 32'hFFFF_F000) | (32'($urandom_range(0, 7)) << 2) | (hi & 32'h3);
        r.wdata = $urandom;
        return r;
    endfunction

    task automatic model_reset();
        favor_m = 0; last_m = 0; cnt0_m = 0; cnt1_m = 0; cont_m = 0;
    endtask

    task automatic idle_inputs();
        c0_MemRequest = 0; c0_MemRead = 0; c0_MemWrite = 0;
        c0_MemAddress = 0; c0_MemWriteData = 0;
        c1_MemRequest = 0; c1_MemRead = 0; c1_MemWrite = 0;
        c1_MemAddress = 0; c1_MemWriteData = 0;
        s_c0_req = 0; s_c1_req = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // One bus cycle: drive at the falling edge, check combinational outputs
    // before the rising edge and registered outputs just after it.
    task automatic run_cycle(input req_t a, input req_t b, input string tag);
        int g;
        int i0, i1;
        c0_MemRequest = a.req; c0_MemRead = a.rd; c0_MemWrite = a.wr;
        c0_MemAddress = a.addr; c0_MemWriteData = a.wdata;
        c1_MemRequest = b.req; c1_MemRead = b.rd; c1_MemWrite = b.wr;
        c1_MemAddress = b.addr; c1_MemWriteData = b.wdata;
        #1;
        if (a.req && b.req) g = favor_m;
        else if (a.req)     g = 0;
        else if (b.req)     g = 1;
        else                g = -1;
        i0 = word_of(a.addr);
        i1 = word_of(b.addr);

        tests_run++;
        if (c0_MemGrant !== (g == 0) || c1_MemGrant !== (g == 1)) begin
            fails++;
            $display("FAIL %s grant: got c0=%b c1=%b, want winner %0d", tag, c0_MemGrant, c1_MemGrant, g);
        end
        if (g == 0 && mem_m.exists(i0)) begin
            tests_run++;
            if (c0_MemReadData !== mem_m[i0]) begin
                fails++;
                $display("FAIL %s c0 rdata: got %h want %h", tag, c0_MemReadData, mem_m[i0]);
            end
        end else if (g != 0) begin
            tests_run++;
            if (c0_MemReadData !== 32'h0) begin
                fails++;
                $display("FAIL %s c0 rdata ungranted: got %h want 0", tag, c0_MemReadData);
            end
        end
        if (g == 1 && mem_m.exists(i1)) begin
            tests_run++;
            if (c1_MemReadData !== mem_m[i1]) begin
                fails++;
                $display("FAIL %s c1 rdata: got %h want %h", tag, c1_MemReadData, mem_m[i1]);
            end
        end else if (g != 1) begin
            tests_run++;
            if (c1_MemReadData !== 32'h0) begin
                fails++;
                $display("FAIL %s c1 rdata ungranted: got %h want 0", tag, c1_MemReadData);
            end
        end

        @(posedge clk);
        if (!rst) begin
            if (g == 0) begin
                if (a.wr) mem_m[i0] = a.wdata;
                cnt0_m = sat_inc(cnt0_m);
            end else if (g == 1) begin
                if (b.wr) mem_m[i1] = b.wdata;
                cnt1_m = sat_inc(cnt1_m);
            end
            if (g >= 0) begin
                favor_m = 1 - g;
                last_m  = g;
            end
            if (a.req && b.req) cont_m = sat_inc(cont_m);
        end
        #1;
        tests_run++;
        if (grant_count0 !== 16'(cnt0_m) || grant_count1 !== 16'(cnt1_m) ||
            contention_count !== 16'(cont_m) || last_grant !== 1'(last_m)) begin
            fails++;
            $display("FAIL %s state: got cnt0=%0d cnt1=%0d cont=%0d last=%b, want %0d %0d %0d %0d",
                     tag, grant_count0, grant_count1, contention_count, last_grant,
                     cnt0_m, cnt1_m, cont_m, last_m);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        c0_MemRequest = 1'b1;
        c0_MemWrite   = 1'b1;
        #1;
        tests_run++;
        if (grant_count0 !== 16'h0 || grant_count1 !== 16'h0 || contention_count !== 16'h0 || last_grant !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: got %0d %0d %0d %b, want 0 0 0 0",
                     grant_count0, grant_count1, contention_count, last_grant);
        end
        tests_run++;
        if (c0_MemGrant !== 1'b1 || c1_MemGrant !== 1'b0) begin
            fails++;
            $display("FAIL reset_comb_grant: got c0=%b c1=%b, want 1 0", c0_MemGrant, c1_MemGrant);
        end
        @(posedge clk);
        #1;
        tests_run++;
        if (grant_count0 !== 16'h0 || last_grant !== 1'b0) begin
            fails++;
            $display("FAIL reset_hold: got cnt0=%0d last=%b, want 0 0", grant_count0, last_grant);
        end
        @(negedge clk);
        do_reset();
    endtask

    task automatic test_store_load();
        do_reset();
        run_cycle(mk(1, 0, 1, 32'h40, 32'hDEADBEEF), mk(0, 0, 0, 0, 0), "c0_store");
        run_cycle(mk(1, 1, 0, 32'h40, 32'h0), mk(0, 0, 0, 0, 0), "c0_load");
        tests_run++;
        if (grant_count0 !== 16'd2) begin
            fails++;
            $display("FAIL store_load_count: got %0d want 2", grant_count0);
        end
    endtask

    task automatic test_contention();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            run_cycle(mk(1, 0, 0, 0, 0), mk(1, 0, 0, 0, 0), "contend");
        end
        tests_run++;
        if (contention_count !== 16'd4 || last_grant !== 1'b1 ||
            grant_count0 !== 16'd2 || grant_count1 !== 16'd2) begin
            fails++;
            $display("FAIL contention_totals: got cont=%0d last=%b c0=%0d c1=%0d, want 4 1 2 2",
                     contention_count, last_grant, grant_count0, grant_count1);
        end
    endtask

    task automatic test_wrap();
        run_cycle(mk(0, 0, 0, 0, 0), mk(1, 0, 1, 32'h400, 32'h12345678), "wrap_store");
        run_cycle(mk(1, 1, 0, 32'h000, 0), mk(0, 0, 0, 0, 0), "wrap_load");
        run_cycle(mk(1, 1, 0, 32'h7, 0), mk(0, 0, 0, 0, 0), "offset_load");
    endtask

    task automatic test_nongranted();
        do_reset();
        run_cycle(mk(0, 0, 0, 0, 0), mk(1, 0, 1, 32'h100, 32'h01010101), "ng_seed");
        run_cycle(mk(1, 1, 0, 32'h100, 0), mk(1, 0, 1, 32'h100, 32'hCAFEF00D), "ng_c1_waits");
        run_cycle(mk(1, 1, 0, 32'h100, 0), mk(1, 0, 1, 32'h100, 32'hCAFEF00D), "ng_c1_wins");
        run_cycle(mk(1, 1, 0, 32'h100, 0), mk(0, 0, 0, 0, 0), "ng_new_data");
    endtask

    task automatic test_reset_blocks_write();
        run_cycle(mk(1, 0, 1, 32'h80, 32'h11111111), mk(0, 0, 0, 0, 0), "rw_seed");
        rst = 1'b1;
        model_reset();
        c0_MemRequest = 1; c0_MemWrite = 1; c0_MemRead = 0;
        c0_MemAddress = 32'h80; c0_MemWriteData = 32'h00000BAD;
        c1_MemRequest = 0;
        @(negedge clk);
        rst = 1'b0;
        run_cycle(mk(1, 1, 0, 32'h80, 0), mk(0, 0, 0, 0, 0), "rw_after_reset");
    endtask

    task automatic test_mid_reset();
        do_reset();
        run_cycle(mk(1, 0, 0, 0, 0), mk(1, 0, 0, 0, 0), "mid_first");
        #2;
        rst = 1'b1;
        #1;
        tests_run++;
        if (grant_count0 !== 16'h0 || grant_count1 !== 16'h0 || contention_count !== 16'h0 || last_grant !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset_clear: got %0d %0d %0d %b, want 0 0 0 0",
                     grant_count0, grant_count1, contention_count, last_grant);
        end
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        #1;
        tests_run++;
        if (c0_MemGrant !== 1'b1 || c1_MemGrant !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset_core0_wins: got c0=%b c1=%b, want 1 0", c0_MemGrant, c1_MemGrant);
        end
        run_cycle(mk(1, 0, 0, 0, 0), mk(1, 0, 0, 0, 0), "mid_after");
    endtask

    task automatic test_saturation();
        do_reset();
        s_c0_req = 1; s_c1_req = 1;
        repeat (10) @(negedge clk);
        #1;
        tests_run++;
        if (s_cont !== 3'd7 || s_cnt0 !== 3'd5 || s_cnt1 !== 3'd5) begin
            fails++;
            $display("FAIL sat_contention: got cont=%0d c0=%0d c1=%0d, want 7 5 5", s_cont, s_cnt0, s_cnt1);
        end
        s_c1_req = 0;
        repeat (4) @(negedge clk);
        #1;
        tests_run++;
        if (s_cnt0 !== 3'd7 || s_cnt1 !== 3'd5 || s_cont !== 3'd7) begin
            fails++;
            $display("FAIL sat_grant: got c0=%0d c1=%0d cont=%0d, want 7 5 7", s_cnt0, s_cnt1, s_cont);
        end
        s_c0_req = 0;
        @(negedge clk);
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            run_cycle(rand_req(), rand_req(), "random");
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        idle_inputs();
        rst = 1'b1;
        test_reset();
        test_store_load();
        test_contention();
        test_wrap();
        test_nongranted();
        test_reset_blocks_write();
        test_mid_reset();
        test_saturation();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
